// File: rtl/csr_regfile.sv
`default_nettype none
// csr_regfile: LoongArch-style CSR file covering exception entry/return state,
// interrupt status/enable, a countdown timer and the TLB search index register.
module csr_regfile (
   input  logic        clk,
   input  logic        resetn,
   input  logic        csr_re,
   input  logic [13:0] csr_num,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   output logic [31:0] csr_rvalue,
   input  logic        wb_ex,
   input  logic        ertn_flush,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_vaddr,
   input  logic        tlbsrch_we,
   input  logic        tlbsrch_hit,
   input  logic [3:0]  tlbsrch_hit_index,
   input  logic [7:0]  hw_int_in,
   output logic        has_int,
   output logic [31:0] ex_entry,
   output logic [31:0] ertn_pc,
   output logic [3:0]  csr_tlbidx_index
);

   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_PRMD   = 14'h001;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00C;
   localparam logic [13:0] CSR_TLBIDX = 14'h010;
   localparam logic [13:0] CSR_SAVE0  = 14'h030;
   localparam logic [13:0] CSR_SAVE1  = 14'h031;
   localparam logic [13:0] CSR_SAVE2  = 14'h032;
   localparam logic [13:0] CSR_SAVE3  = 14'h033;
   localparam logic [13:0] CSR_TID    = 14'h040;
   localparam logic [13:0] CSR_TCFG   = 14'h041;
   localparam logic [13:0] CSR_TVAL   = 14'h042;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   localparam logic [5:0]  ECODE_PIL  = 6'h01;
   localparam logic [5:0]  ECODE_PIS  = 6'h02;
   localparam logic [5:0]  ECODE_PIF  = 6'h03;
   localparam logic [5:0]  ECODE_PME  = 6'h04;
   localparam logic [5:0]  ECODE_PPI  = 6'h07;
   localparam logic [5:0]  ECODE_ADE  = 6'h08;
   localparam logic [5:0]  ECODE_ALE  = 6'h09;
   localparam logic [5:0]  ECODE_TLBR = 6'h3F;

   localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

   logic [1:0]  crmd_plv_q,     crmd_plv_d;
   logic        crmd_ie_q,      crmd_ie_d;
   logic        crmd_da_q,      crmd_da_d;
   logic [1:0]  prmd_pplv_q,    prmd_pplv_d;
   logic        prmd_pie_q,     prmd_pie_d;
   logic [12:0] ecfg_lie_q,     ecfg_lie_d;
   logic [1:0]  estat_swi_q,    estat_swi_d;
   logic [7:0]  estat_hwi_q,    estat_hwi_d;
   logic        estat_ti_q,     estat_ti_d;
   logic [5:0]  estat_ecode_q,  estat_ecode_d;
   logic [8:0]  estat_esub_q,   estat_esub_d;
   logic [31:0] era_q,          era_d;
   logic [31:0] badv_q,         badv_d;
   logic [25:0] eentry_va_q,    eentry_va_d;
   logic [3:0]  tlbidx_index_q, tlbidx_index_d;
   logic        tlbidx_ne_q,    tlbidx_ne_d;
   logic [31:0] save_q [4];
   logic [31:0] save_d [4];
   logic [31:0] tid_q,          tid_d;
   logic        tcfg_en_q,      tcfg_en_d;
   logic        tcfg_periodic_q, tcfg_periodic_d;
   logic [29:0] tcfg_initval_q, tcfg_initval_d;
   logic [31:0] tval_q,         tval_d;

   logic [12:0] estat_is;
   logic [31:0] crmd_rd;
   logic [31:0] prmd_rd;
   logic [31:0] ecfg_rd;
   logic [31:0] estat_rd;
   logic [31:0] eentry_rd;
   logic [31:0] tlbidx_rd;
   logic [31:0] tcfg_rd;

   logic        wr_en;
   logic [31:0] wr_data;
   logic        tcfg_wr;
   logic        ticlr_wr;
   logic        timer_fire;
   logic        unused_ok;

   assign unused_ok = csr_re;

   assign estat_is  = {1'b0, estat_ti_q, 1'b0, estat_hwi_q, estat_swi_q};
   assign crmd_rd   = {28'd0, crmd_da_q, crmd_ie_q, crmd_plv_q};
   assign prmd_rd   = {29'd0, prmd_pie_q, prmd_pplv_q};
   assign ecfg_rd   = {19'd0, ecfg_lie_q};
   assign estat_rd  = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_is};
   assign eentry_rd = {eentry_va_q, 6'd0};
   assign tlbidx_rd = {tlbidx_ne_q, 27'd0, tlbidx_index_q};
   assign tcfg_rd   = {tcfg_initval_q, tcfg_periodic_q, tcfg_en_q};

   always_comb begin
      csr_rvalue = 32'd0;
      case (csr_num)
         CSR_CRMD:   csr_rvalue = crmd_rd;
         CSR_PRMD:   csr_rvalue = prmd_rd;
         CSR_ECFG:   csr_rvalue = ecfg_rd;
         CSR_ESTAT:  csr_rvalue = estat_rd;
         CSR_ERA:    csr_rvalue = era_q;
         CSR_BADV:   csr_rvalue = badv_q;
         CSR_EENTRY: csr_rvalue = eentry_rd;
         CSR_TLBIDX: csr_rvalue = tlbidx_rd;
         CSR_SAVE0:  csr_rvalue = save_q[0];
         CSR_SAVE1:  csr_rvalue = save_q[1];
         CSR_SAVE2:  csr_rvalue = save_q[2];
         CSR_SAVE3:  csr_rvalue = save_q[3];
         CSR_TID:    csr_rvalue = tid_q;
         CSR_TCFG:   csr_rvalue = tcfg_rd;
         CSR_TVAL:   csr_rvalue = tval_q;
         default:    csr_rvalue = 32'd0;
      endcase
   end

   // The read mux already holds the addressed register, so one masked merge
   // serves every writable CSR; TICLR reads 0, leaving just the masked wvalue.
   assign wr_en      = csr_we & ~wb_ex & ~ertn_flush;
   assign wr_data    = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
   assign tcfg_wr    = wr_en && (csr_num == CSR_TCFG);
   assign ticlr_wr   = wr_en && (csr_num == CSR_TICLR) && wr_data[0];
   assign timer_fire = !tcfg_wr && tcfg_en_q && (tval_q == 32'd1);

   always_comb begin
      crmd_plv_d      = crmd_plv_q;
      crmd_ie_d       = crmd_ie_q;
      crmd_da_d       = crmd_da_q;
      prmd_pplv_d     = prmd_pplv_q;
      prmd_pie_d      = prmd_pie_q;
      ecfg_lie_d      = ecfg_lie_q;
      estat_swi_d     = estat_swi_q;
      estat_hwi_d     = hw_int_in;
      estat_ti_d      = estat_ti_q;
      estat_ecode_d   = estat_ecode_q;
      estat_esub_d    = estat_esub_q;
      era_d           = era_q;
      badv_d          = badv_q;
      eentry_va_d     = eentry_va_q;
      tlbidx_index_d  = tlbidx_index_q;
      tlbidx_ne_d     = tlbidx_ne_q;
      save_d          = save_q;
      tid_d           = tid_q;
      tcfg_en_d       = tcfg_en_q;
      tcfg_periodic_d = tcfg_periodic_q;
      tcfg_initval_d  = tcfg_initval_q;
      tval_d          = tval_q;

      if (wr_en) begin
         case (csr_num)
            CSR_CRMD: begin
               crmd_plv_d = wr_data[1:0];
               crmd_ie_d  = wr_data[2];
               crmd_da_d  = wr_data[3];
            end
            CSR_PRMD: begin
               prmd_pplv_d = wr_data[1:0];
               prmd_pie_d  = wr_data[2];
            end
            CSR_ECFG:   ecfg_lie_d  = wr_data[12:0] & ECFG_LIE_MASK;
            CSR_ESTAT:  estat_swi_d = wr_data[1:0];
            CSR_ERA:    era_d       = wr_data;
            CSR_BADV:   badv_d      = wr_data;
            CSR_EENTRY: eentry_va_d = wr_data[31:6];
            CSR_TLBIDX: begin
               tlbidx_index_d = wr_data[3:0];
               tlbidx_ne_d    = wr_data[31];
            end
            CSR_SAVE0:  save_d[0]   = wr_data;
            CSR_SAVE1:  save_d[1]   = wr_data;
            CSR_SAVE2:  save_d[2]   = wr_data;
            CSR_SAVE3:  save_d[3]   = wr_data;
            CSR_TID:    tid_d       = wr_data;
            CSR_TCFG: begin
               tcfg_en_d       = wr_data[0];
               tcfg_periodic_d = wr_data[1];
               tcfg_initval_d  = wr_data[31:2];
            end
            default: ;
         endcase
      end

      if (tlbsrch_we) begin
         if (tlbsrch_hit) begin
            tlbidx_index_d = tlbsrch_hit_index;
            tlbidx_ne_d    = 1'b0;
         end else begin
            tlbidx_ne_d    = 1'b1;
         end
      end

      if (wb_ex) begin
         prmd_pplv_d   = crmd_plv_q;
         prmd_pie_d    = crmd_ie_q;
         crmd_plv_d    = 2'd0;
         crmd_ie_d     = 1'b0;
         estat_ecode_d = wb_ecode;
         estat_esub_d  = wb_esubcode;
         era_d         = wb_pc;
         if (wb_ecode == ECODE_TLBR) begin
            crmd_da_d = 1'b1;
         end
         case (wb_ecode)
            ECODE_ADE: badv_d = wb_pc;
            ECODE_ALE, ECODE_TLBR, ECODE_PIL, ECODE_PIS,
            ECODE_PIF, ECODE_PME, ECODE_PPI: badv_d = wb_vaddr;
            default: ;
         endcase
      end else if (ertn_flush) begin
         crmd_plv_d = prmd_pplv_q;
         crmd_ie_d  = prmd_pie_q;
      end

      // A reload only follows an expiry; a one-shot timer parks at zero.
      if (tcfg_wr) begin
         tval_d = {wr_data[31:2], 2'b00};
      end else if (tcfg_en_q) begin
         if (tval_q != 32'd0) begin
            tval_d = tval_q - 32'd1;
         end else if (tcfg_periodic_q) begin
            tval_d = {tcfg_initval_q, 2'b00};
         end
      end

      if (timer_fire) begin
         estat_ti_d = 1'b1;
      end else if (ticlr_wr) begin
         estat_ti_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         crmd_plv_q      <= 2'd0;
         crmd_ie_q       <= 1'b0;
         crmd_da_q       <= 1'b1;
         prmd_pplv_q     <= 2'd0;
         prmd_pie_q      <= 1'b0;
         ecfg_lie_q      <= 13'd0;
         estat_swi_q     <= 2'd0;
         estat_hwi_q     <= 8'd0;
         estat_ti_q      <= 1'b0;
         estat_ecode_q   <= 6'd0;
         estat_esub_q    <= 9'd0;
         era_q           <= 32'd0;
         badv_q          <= 32'd0;
         eentry_va_q     <= 26'd0;
         tlbidx_index_q  <= 4'd0;
         tlbidx_ne_q     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            save_q[i] <= 32'd0;
         end
         tid_q           <= 32'd0;
         tcfg_en_q       <= 1'b0;
         tcfg_periodic_q <= 1'b0;
         tcfg_initval_q  <= 30'd0;
         tval_q          <= 32'd0;
      end else begin
         crmd_plv_q      <= crmd_plv_d;
         crmd_ie_q       <= crmd_ie_d;
         crmd_da_q       <= crmd_da_d;
         prmd_pplv_q     <= prmd_pplv_d;
         prmd_pie_q      <= prmd_pie_d;
         ecfg_lie_q      <= ecfg_lie_d;
         estat_swi_q     <= estat_swi_d;
         estat_hwi_q     <= estat_hwi_d;
         estat_ti_q      <= estat_ti_d;
         estat_ecode_q   <= estat_ecode_d;
         estat_esub_q    <= estat_esub_d;
         era_q           <= era_d;
         badv_q          <= badv_d;
         eentry_va_q     <= eentry_va_d;
         tlbidx_index_q  <= tlbidx_index_d;
         tlbidx_ne_q     <= tlbidx_ne_d;
         save_q          <= save_d;
         tid_q           <= tid_d;
         tcfg_en_q       <= tcfg_en_d;
         tcfg_periodic_q <= tcfg_periodic_d;
         tcfg_initval_q  <= tcfg_initval_d;
         tval_q          <= tval_d;
      end
   end

   assign has_int          = crmd_ie_q & |(estat_is & ecfg_lie_q);
   assign ex_entry         = eentry_rd;
   assign ertn_pc          = era_q;
   assign csr_tlbidx_index = tlbidx_index_q;

endmodule
`default_nettype wire
